// File: rtl/alu_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_frame_sequencer
// Purpose  : Sits between a UART RX byte stream, an ALU and a UART TX.
//            Collects a 3-byte frame (A, B, OP) and issues one ALU request.
//            Then sends the result byte to the TX with a start/done handshake.
//            An inter-byte timeout drops partial frames. RX bytes that arrive
//            while a frame is being processed are dropped and flagged.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk         system clock
//   i_rst         asynchronous active-low reset
//   i_rx_data     received byte, valid while i_rx_done=1
//   i_rx_done     one-cycle pulse, new RX byte
//   o_a / o_b     registered ALU operands
//   o_op          registered ALU operator (OP byte bits [NB_OPERADOR-1:0])
//   o_alu_valid   one-cycle ALU request pulse
//   i_alu_result  ALU result
//   i_alu_done    ALU result valid pulse
//   o_tx_data     byte to transmit
//   o_tx_start    one-cycle TX start pulse
//   i_tx_done     one-cycle pulse, TX finished the byte
//   o_busy        high in every state except S_IDLE
//   o_frame_err   one-cycle pulse on inter-byte timeout
//   o_overrun     one-cycle pulse when an RX byte is dropped
// Build option
//   ALU_SEQ_ECHO_EN  when defined, the sequencer transmits A, B and then the
//                    result. Otherwise it transmits the result only.
// ============================================================================
module alu_frame_sequencer #(
  parameter int NB_DATA     = 8,
  parameter int NB_OPERADOR = 6,
  parameter int TIMEOUT_CYC = 1000,
  parameter int NB_TIMER    = 10
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NB_DATA-1:0]     i_rx_data,
  input  logic                   i_rx_done,
  output logic [NB_DATA-1:0]     o_a,
  output logic [NB_DATA-1:0]     o_b,
  output logic [NB_OPERADOR-1:0] o_op,
  output logic                   o_alu_valid,
  input  logic [NB_DATA-1:0]     i_alu_result,
  input  logic                   i_alu_done,
  output logic [NB_DATA-1:0]     o_tx_data,
  output logic                   o_tx_start,
  input  logic                   i_tx_done,
  output logic                   o_busy,
  output logic                   o_frame_err,
  output logic                   o_overrun
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GET_B    = 3'd1,
    S_GET_OP   = 3'd2,
    S_ALU_REQ  = 3'd3,
    S_ALU_WAIT = 3'd4,
    S_TX_LOAD  = 3'd5,
    S_TX_WAIT  = 3'd6
  } state_t;

  // The error pulse is registered. It must be visible in the same cycle the
  // timer reaches TIMEOUT_CYC-1, so expiry is detected one count earlier.
  localparam logic [NB_TIMER-1:0] TIMER_LAST = NB_TIMER'(TIMEOUT_CYC - 2);

  state_t                   state_q;
  logic [NB_TIMER-1:0]      timer_q;
  logic [NB_DATA-1:0]       a_q;
  logic [NB_DATA-1:0]       b_q;
  logic [NB_OPERADOR-1:0]   op_q;
  logic [NB_DATA-1:0]       res_q;
  logic [NB_DATA-1:0]       tx_data_q;
  logic                     alu_valid_q;
  logic                     tx_start_q;
  logic                     busy_q;
  logic                     frame_err_q;
  logic                     overrun_q;

  logic                     timer_expire_d;
  logic [NB_DATA-1:0]       tx_byte_d;

  assign timer_expire_d = (timer_q == TIMER_LAST);

`ifdef ALU_SEQ_ECHO_EN
  // Index of the byte being transmitted: 0=A, 1=B, 2=result.
  logic [1:0] idx_q;

  always_comb begin
    tx_byte_d = res_q;
    case (idx_q)
      2'd0:    tx_byte_d = a_q;
      2'd1:    tx_byte_d = b_q;
      default: tx_byte_d = res_q;
    endcase
  end
`else
  assign tx_byte_d = res_q;
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      res_q       <= '0;
      tx_data_q   <= '0;
      alu_valid_q <= 1'b0;
      tx_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef ALU_SEQ_ECHO_EN
      idx_q       <= 2'd0;
`endif
    end else begin
      alu_valid_q <= 1'b0;
      tx_start_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (i_rx_done) begin
            a_q     <= i_rx_data;
            timer_q <= '0;
            busy_q  <= 1'b1;
            state_q <= S_GET_B;
          end
        end

        S_GET_B: begin
          // When a byte and expiry land in the same cycle, the byte takes priority.
          if (i_rx_done) begin
            b_q     <= i_rx_data;
            timer_q <= '0;
            state_q <= S_GET_OP;
          end else if (timer_expire_d) begin
            frame_err_q <= 1'b1;
            timer_q     <= '0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end else begin
            timer_q <= timer_q + NB_TIMER'(1);
          end
        end

        S_GET_OP: begin
          if (i_rx_done) begin
            op_q    <= i_rx_data[NB_OPERADOR-1:0];
            timer_q <= '0;
            state_q <= S_ALU_REQ;
          end else if (timer_expire_d) begin
            frame_err_q <= 1'b1;
            timer_q     <= '0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end else begin
            timer_q <= timer_q + NB_TIMER'(1);
          end
        end

        S_ALU_REQ: begin
          overrun_q   <= i_rx_done;
          alu_valid_q <= 1'b1;
          state_q     <= S_ALU_WAIT;
        end

        S_ALU_WAIT: begin
          overrun_q <= i_rx_done;
          if (i_alu_done) begin
            res_q   <= i_alu_result;
            state_q <= S_TX_LOAD;
          end
        end

        S_TX_LOAD: begin
          overrun_q  <= i_rx_done;
          tx_data_q  <= tx_byte_d;
          tx_start_q <= 1'b1;
          state_q    <= S_TX_WAIT;
        end

        S_TX_WAIT: begin
          overrun_q <= i_rx_done;
          if (i_tx_done) begin
`ifdef ALU_SEQ_ECHO_EN
            if (idx_q == 2'd2) begin
              idx_q   <= 2'd0;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              idx_q   <= idx_q + 2'd1;
              state_q <= S_TX_LOAD;
            end
`else
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
`endif
          end
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_a         = a_q;
  assign o_b         = b_q;
  assign o_op        = op_q;
  assign o_alu_valid = alu_valid_q;
  assign o_tx_data   = tx_data_q;
  assign o_tx_start  = tx_start_q;
  assign o_busy      = busy_q;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;

endmodule
`default_nettype wire

// File: doc/alu_frame_sequencer.md
Name: alu_frame_sequencer

Overview:
- Controller between the UART RX byte stream, the ALU and the UART TX.
- Collects a 3-byte command frame (A, B, OP), fires one ALU request, then sequences the result byte into the TX with a start/done handshake.
- Adds an inter-byte timeout, overrun detection and busy status, so a partial or garbled frame cannot hang the datapath.

Parameters:
- NB_DATA, 8, width of RX/TX bytes, ALU operands and ALU result.
- NB_OPERADOR, 6, width of the ALU operator field, taken from OP byte bits [NB_OPERADOR-1:0].
- TIMEOUT_CYC, 1000, maximum i_clk cycles allowed between consecutive frame bytes. Must be ≥ 2.
- NB_TIMER, 10, counter width. Must satisfy 2^NB_TIMER > TIMEOUT_CYC.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous active-low reset
- i_rx_data  in  NB_DATA  received byte, valid while i_rx_done=1
- i_rx_done  in  1  one-cycle pulse, new RX byte
- o_a  out  NB_DATA  registered operand A to the ALU
- o_b  out  NB_DATA  registered operand B to the ALU
- o_op  out  NB_OPERADOR  registered operator to the ALU
- o_alu_valid  out  1  one-cycle request pulse to the ALU
- i_alu_result  in  NB_DATA  ALU result
- i_alu_done  in  1  ALU result valid pulse
- o_tx_data  out  NB_DATA  byte to transmit
- o_tx_start  out  1  one-cycle TX start pulse
- i_tx_done  in  1  one-cycle pulse, TX finished the byte
- o_busy  out  1  high in every state except S_IDLE
- o_frame_err  out  1  one-cycle pulse on inter-byte timeout
- o_overrun  out  1  one-cycle pulse when an RX byte is dropped

Behaviour:
- Reset (i_rst=0, asynchronous):
  - state=S_IDLE.
  - o_a, o_b, o_op, o_tx_data, the result register and the timer all clear to 0.
  - All pulse outputs and o_busy are 0.
- Reset mid-frame or mid-TX aborts immediately. No pending TX start is issued after release.
- State machine (all transitions are registered):
  - S_IDLE: on i_rx_done, latch o_a and go to S_GET_B. Timer clears.
  - S_GET_B: on i_rx_done, latch o_b and go to S_GET_OP. Timer clears.
  - S_GET_OP: on i_rx_done, latch o_op=i_rx_data[NB_OPERADOR-1:0] and go to S_ALU_REQ. Upper OP bits are ignored.
  - S_ALU_REQ: o_alu_valid=1 for exactly one cycle, then go to S_ALU_WAIT.
  - S_ALU_WAIT: on i_alu_done (same cycle or later), latch i_alu_result into the result register and go to S_TX_LOAD.
  - S_TX_LOAD: drive o_tx_data from the TX byte queue, o_tx_start=1 for one cycle, then go to S_TX_WAIT.
  - S_TX_WAIT: on i_tx_done, go to S_TX_LOAD if more bytes are queued, else to S_IDLE.
- Latency: third RX pulse at cycle n → o_alu_valid at n+2. i_alu_done at m → o_tx_start at m+2.
- Timeout:
  - In S_GET_B and S_GET_OP the timer increments each cycle.
  - When the timer reaches TIMEOUT_CYC-1 without i_rx_done: pulse o_frame_err, return to S_IDLE, discard partial operands (registers keep their old values, no ALU request).
  - If i_rx_done and expiry occur in the same cycle, the byte wins and there is no error.
- Overrun: i_rx_done in any of S_ALU_REQ, S_ALU_WAIT, S_TX_LOAD, S_TX_WAIT drops the byte and pulses o_overrun. The state is unaffected.
- A stray i_tx_done outside S_TX_WAIT and a stray i_alu_done outside S_ALU_WAIT are ignored.
- o_a, o_b and o_op hold stable from latch until the next frame overwrites them.

Optional Feature:
- Macro: ALU_SEQ_ECHO_EN.
- Defined: the TX queue is A, B, result (3 bytes, in that order, each with its own start/done handshake). S_TX_WAIT returns to S_TX_LOAD until all 3 bytes are sent.
- Undefined: the TX queue is the result byte only. No echo logic or byte index counter is synthesized.

Test Plan:
- RX bytes 0x04, 0x02, 0x20 (ADD) spaced 10 cycles apart; ALU done 1 cycle after valid → o_alu_valid pulses once with o_a=4, o_b=2, o_op=0x20; o_tx_data=0x06 with one o_tx_start; o_busy falls 1 cycle after i_tx_done.
- RX 0x06, 0x03 then silence, TIMEOUT_CYC=16 → o_frame_err pulses 16 cycles after the second byte; no o_alu_valid; a following full frame 0x06, 0x03, 0x22 processes normally.
- Frame 0x04, 0x02, 0x20, then extra RX byte 0x55 while in S_TX_WAIT → o_overrun pulses once; result 0x06 is still sent; 0x55 is not treated as a new A.
- i_tx_done held off for 50 cycles → no second o_tx_start, o_busy stays 1; state returns to S_IDLE only after i_tx_done.
- i_rst driven low while in S_ALU_WAIT, then released → all outputs 0; a late i_alu_done produces no TX start.
- With ALU_SEQ_ECHO_EN defined, frame 0x04, 0x02, 0x20 → three o_tx_start pulses carrying 0x04, 0x02, 0x06, each issued only after the previous i_tx_done.
